// File: rtl/mesi_bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared MESI snoop bus.
// Grants one requester, broadcasts its request, gathers snoop acks/shared flags and returns completion.
module mesi_bus_arbiter #(
  parameter int unsigned N_CACHES      = 4,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned SNOOP_TIMEOUT = 15,
  localparam int unsigned SRC_W        = (N_CACHES > 1) ? $clog2(N_CACHES) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_CACHES-1:0]          req_i,
  input  logic [2*N_CACHES-1:0]        req_type_i,
  input  logic [ADDR_W*N_CACHES-1:0]   req_addr_i,
  output logic [N_CACHES-1:0]          gnt_o,
  output logic                         bus_valid_o,
  output logic [1:0]                   bus_type_o,
  output logic [ADDR_W-1:0]            bus_addr_o,
  output logic [SRC_W-1:0]             bus_src_o,
  input  logic [N_CACHES-1:0]          snoop_ack_i,
  input  logic [N_CACHES-1:0]          snoop_shared_i,
  output logic [N_CACHES-1:0]          done_o,
  output logic                         bus_shared_o,
  output logic                         timeout_o
);

  localparam int unsigned TMR_W = $clog2(SNOOP_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, BUS, SNOOP, RESP} state_e;

  state_e                state_q, state_d;
  logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]      win_q, win_d;
  logic [1:0]            type_q, type_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [N_CACHES-1:0]   ack_acc_q, ack_acc_d;
  logic [N_CACHES-1:0]   shr_acc_q, shr_acc_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic                  tmo_q, tmo_d;

  logic [N_CACHES-1:0]   gnt_q, gnt_d;
  logic                  bus_valid_q, bus_valid_d;
  logic [1:0]            bus_type_q, bus_type_d;
  logic [ADDR_W-1:0]     bus_addr_q, bus_addr_d;
  logic [SRC_W-1:0]      bus_src_q, bus_src_d;
  logic [N_CACHES-1:0]   done_q, done_d;
  logic                  bus_shared_q, bus_shared_d;
  logic                  timeout_q, timeout_d;

  logic [N_CACHES-1:0]   elig;
  logic                  found;
  int unsigned           pick;
  int unsigned           idx;
  logic [1:0]            pick_type;
  logic [ADDR_W-1:0]     pick_addr;
  logic [N_CACHES-1:0]   src_mask;
  logic [N_CACHES-1:0]   win_mask_d;
  logic [N_CACHES-1:0]   ack_new;
  logic [N_CACHES-1:0]   shr_new;

  // Round-robin scan starting at rr_ptr for the first eligible requester
  always_comb begin
    elig      = '0;
    found     = 1'b0;
    pick      = 0;
    idx       = 0;
    pick_type = '0;
    pick_addr = '0;
    for (int i = 0; i < int'(N_CACHES); i++) begin
      elig[i] = req_i[i] && (req_type_i[2*i +: 2] != 2'b00);
    end
    for (int unsigned k = 0; k < N_CACHES; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_CACHES) idx = idx - N_CACHES;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    for (int unsigned i = 0; i < N_CACHES; i++) begin
      if (i == pick) begin
        pick_type = req_type_i[2*i +: 2];
        pick_addr = req_addr_i[ADDR_W*i +: ADDR_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    win_d     = win_q;
    type_d    = type_q;
    addr_d    = addr_q;
    ack_acc_d = ack_acc_q;
    shr_acc_d = shr_acc_q;
    timer_d   = timer_q;
    tmo_d     = tmo_q;
    src_mask  = N_CACHES'(1) << win_q;
    // Source cache's own ack/shared never counts toward completion or sharing
    ack_new   = ack_acc_q | (snoop_ack_i & ~src_mask);
    shr_new   = shr_acc_q | (snoop_ack_i & snoop_shared_i & ~src_mask);

    unique case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = SRC_W'(pick);
          type_d  = pick_type;
          addr_d  = pick_addr;
          state_d = BUS;
        end
      end
      BUS: begin
        ack_acc_d = '0;
        shr_acc_d = '0;
        timer_d   = '0;
        tmo_d     = 1'b0;
        state_d   = SNOOP;
      end
      SNOOP: begin
        ack_acc_d = ack_new;
        shr_acc_d = shr_new;
        if ((ack_new | src_mask) == '1) begin
          state_d = RESP;
        end else if (timer_q == TMR_W'(SNOOP_TIMEOUT - 1)) begin
          state_d = RESP;
          tmo_d   = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      RESP: begin
        rr_ptr_d = (win_q == SRC_W'(N_CACHES - 1)) ? '0 : win_q + SRC_W'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs registered from the next state and next latched data
    win_mask_d   = N_CACHES'(1) << win_d;
    gnt_d        = '0;
    bus_valid_d  = 1'b0;
    bus_type_d   = '0;
    bus_addr_d   = '0;
    bus_src_d    = '0;
    done_d       = '0;
    bus_shared_d = 1'b0;
    timeout_d    = 1'b0;
    if (state_d != IDLE) begin
      gnt_d      = win_mask_d;
      bus_type_d = type_d;
      bus_addr_d = addr_d;
      bus_src_d  = win_d;
    end
    if (state_d == BUS) bus_valid_d = 1'b1;
    if (state_d == RESP) begin
      done_d       = win_mask_d;
      bus_shared_d = |shr_acc_d;
      timeout_d    = tmo_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      win_q        <= '0;
      type_q       <= '0;
      addr_q       <= '0;
      ack_acc_q    <= '0;
      shr_acc_q    <= '0;
      timer_q      <= '0;
      tmo_q        <= 1'b0;
      gnt_q        <= '0;
      bus_valid_q  <= 1'b0;
      bus_type_q   <= '0;
      bus_addr_q   <= '0;
      bus_src_q    <= '0;
      done_q       <= '0;
      bus_shared_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      win_q        <= win_d;
      type_q       <= type_d;
      addr_q       <= addr_d;
      ack_acc_q    <= ack_acc_d;
      shr_acc_q    <= shr_acc_d;
      timer_q      <= timer_d;
      tmo_q        <= tmo_d;
      gnt_q        <= gnt_d;
      bus_valid_q  <= bus_valid_d;
      bus_type_q   <= bus_type_d;
      bus_addr_q   <= bus_addr_d;
      bus_src_q    <= bus_src_d;
      done_q       <= done_d;
      bus_shared_q <= bus_shared_d;
      timeout_q    <= timeout_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign bus_valid_o  = bus_valid_q;
  assign bus_type_o   = bus_type_q;
  assign bus_addr_o   = bus_addr_q;
  assign bus_src_o    = bus_src_q;
  assign done_o       = done_q;
  assign bus_shared_o = bus_shared_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// Scoreboard bench for mesi_bus_arbiter: expected transactions are queued at stimulus time
// and matched against the broadcast strobe and the completion pulse.
module tb_mesi_bus_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 15;
  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] RD  = 2'b01;
  localparam logic [1:0] WR  = 2'b10;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_i;
  logic [2*N-1:0]  req_type_i;
  logic [AW*N-1:0] req_addr_i;
  logic [N-1:0]    gnt_o;
  logic            bus_valid_o;
  logic [1:0]      bus_type_o;
  logic [AW-1:0]   bus_addr_o;
  logic [1:0]      bus_src_o;
  logic [N-1:0]    snoop_ack_i;
  logic [N-1:0]    snoop_shared_i;
  logic [N-1:0]    done_o;
  logic            bus_shared_o;
  logic            timeout_o;

  mesi_bus_arbiter #(.N_CACHES(N), .ADDR_W(AW), .SNOOP_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_type_i(req_type_i), .req_addr_i(req_addr_i),
    .gnt_o(gnt_o), .bus_valid_o(bus_valid_o), .bus_type_o(bus_type_o), .bus_addr_o(bus_addr_o),
    .bus_src_o(bus_src_o), .snoop_ack_i(snoop_ack_i), .snoop_shared_i(snoop_shared_i),
    .done_o(done_o), .bus_shared_o(bus_shared_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    typ;
    logic [AW-1:0] addr;
    int            src;
    logic          shared;
    logic          tmo;
    int            lat;      // BUS cycle to RESP cycle
    int            bus_cyc;  // required BUS cycle, -1 = unconstrained
    int            gap;      // required spacing from previous done, 0 = unconstrained
  } exp_t;

  exp_t         sb_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  int           mon_bus_cyc = 0;
  int           mon_last_done = 0;
  logic         mon_prev_bv = 1'b0;
  logic         mon_en = 1'b0;
  logic [N-1:0] ack_mask = '0;
  logic [N-1:0] shr_mask = '0;
  int           ack_dly = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] one = 1;
    return one << i;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] typ, input logic [AW-1:0] addr);
    req_type_i[2*i +: 2]  = typ;
    req_addr_i[AW*i +: AW] = addr;
    req_i[i]              = 1'b1;
  endtask

  task automatic push(input int src, input logic [1:0] typ, input logic [AW-1:0] addr,
                      input logic shared, input logic tmo, input int lat, input int bcyc,
                      input int gap);
    exp_t e;
    e.typ = typ; e.addr = addr; e.src = src; e.shared = shared; e.tmo = tmo;
    e.lat = lat; e.bus_cyc = bcyc; e.gap = gap;
    sb_q.push_back(e);
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 64; k++) begin
      @(negedge clk);
      if (done_o != '0) break;
    end
    if (k == 64) check_eq("wait_done_bound", 64'(done_o != '0), 64'd1);
  endtask

  task automatic wait_bus();
    int k;
    for (k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bus_valid_o) break;
    end
    if (k == 64) check_eq("wait_bus_bound", 64'(bus_valid_o), 64'd1);
  endtask

  // Snoopers: respond ack_dly negedges after the broadcast with the configured masks
  initial begin
    int   cnt;
    logic active;
    cnt = 0;
    active = 1'b0;
    snoop_ack_i = '0;
    snoop_shared_i = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || done_o != '0) begin
        active = 1'b0;
        snoop_ack_i = '0;
        snoop_shared_i = '0;
      end else if (bus_valid_o) begin
        active = 1'b1;
        cnt = ack_dly;
      end
      if (active) begin
        if (cnt == 0) begin
          snoop_ack_i = ack_mask;
          snoop_shared_i = shr_mask;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Monitor: match broadcasts and completions against the scoreboard
  initial begin
    exp_t cur;
    forever begin
      @(negedge clk);
      if (rst_n && mon_en) begin
        if (bus_valid_o) begin
          check_eq("bus_valid_one_cycle", 64'(mon_prev_bv), 64'd0);
          if (sb_q.size() == 0) begin
            check_eq("bus_unexpected", 64'(bus_valid_o), 64'd0);
          end else begin
            cur = sb_q[0];
            check_eq("bus_type", 64'(bus_type_o), 64'(cur.typ));
            check_eq("bus_addr", 64'(bus_addr_o), 64'(cur.addr));
            check_eq("bus_src", 64'(bus_src_o), 64'(cur.src));
            check_eq("bus_gnt", 64'(gnt_o), 64'(onehot(cur.src)));
            if (cur.bus_cyc >= 0) check_eq("bus_latency", 64'(cyc), 64'(cur.bus_cyc));
            mon_bus_cyc = cyc;
          end
        end
        if (done_o != '0) begin
          if (sb_q.size() == 0) begin
            check_eq("done_unexpected", 64'(done_o), 64'd0);
          end else begin
            cur = sb_q.pop_front();
            check_eq("done_mask", 64'(done_o), 64'(onehot(cur.src)));
            check_eq("done_shared", 64'(bus_shared_o), 64'(cur.shared));
            check_eq("done_timeout", 64'(timeout_o), 64'(cur.tmo));
            check_eq("done_gnt", 64'(gnt_o), 64'(onehot(cur.src)));
            check_eq("done_latency", 64'(cyc - mon_bus_cyc), 64'(cur.lat));
            if (cur.gap > 0) check_eq("done_spacing", 64'(cyc - mon_last_done), 64'(cur.gap));
          end
          mon_last_done = cyc;
        end
      end
      mon_prev_bv = bus_valid_o;
    end
  end

  initial begin
    int seen;
    rst_n = 1'b0;
    req_i = '0;
    req_type_i = '0;
    req_addr_i = '0;
    tick(3);
    check_eq("rst_gnt", 64'(gnt_o), 64'd0);
    check_eq("rst_bus_valid", 64'(bus_valid_o), 64'd0);
    check_eq("rst_bus_type", 64'(bus_type_o), 64'd0);
    check_eq("rst_bus_addr", 64'(bus_addr_o), 64'd0);
    check_eq("rst_done", 64'(done_o), 64'd0);
    check_eq("rst_timeout", 64'(timeout_o), 64'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick(2);

    // Single RD from cache1, cache2 reports shared
    ack_mask = 4'b1101; shr_mask = 4'b0100; ack_dly = 0;
    set_req(1, RD, 32'h40);
    push(1, RD, 32'h40, 1'b1, 1'b0, 2, cyc + 1, 0);
    wait_done();
    req_i[1] = 1'b0;
    tick(3);

    // Reset in SNOOP: outputs clear at once, no completion, rr_ptr back to 0
    mon_en = 1'b0;
    ack_mask = '0; shr_mask = '0;
    set_req(2, RD, 32'h80);
    tick(4);
    check_eq("pre_rst_gnt", 64'(gnt_o), 64'(onehot(2)));
    rst_n = 1'b0;
    #1;
    check_eq("midrst_gnt", 64'(gnt_o), 64'd0);
    check_eq("midrst_bus_src", 64'(bus_src_o), 64'd0);
    check_eq("midrst_done", 64'(done_o), 64'd0);
    check_eq("midrst_shared", 64'(bus_shared_o), 64'd0);
    req_i = '0;
    tick(2);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_o != '0 || bus_valid_o) seen++;
    end
    check_eq("post_rst_quiet", 64'(seen), 64'd0);
    tick(1);
    mon_en = 1'b1;
    ack_mask = 4'b1111; shr_mask = '0;
    set_req(0, RD, 32'h10);
    set_req(3, WR, 32'h30);
    push(0, RD, 32'h10, 1'b0, 1'b0, 2, cyc + 1, 0);
    push(3, WR, 32'h30, 1'b0, 1'b0, 2, -1, 4);
    wait_done();
    req_i[0] = 1'b0;
    wait_done();
    req_i[3] = 1'b0;
    tick(3);

    // Round robin with all four requesting continuously
    ack_mask = 4'b1111; shr_mask = '0;
    for (int i = 0; i < int'(N); i++) set_req(i, RD, AW'(32'h100 + 16 * i));
    for (int k = 0; k < 5; k++) begin
      int s;
      s = k % int'(N);
      push(s, RD, AW'(32'h100 + 16 * s), 1'b0, 1'b0, 2, (k == 0) ? cyc + 1 : -1, (k == 0) ? 0 : 4);
    end
    for (int k = 0; k < 5; k++) wait_done();
    req_i = '0;
    tick(3);

    // Timeout: cache3 never acks; its shared bit and the source's are ignored
    ack_mask = 4'b0111; shr_mask = 4'b1001;
    set_req(0, WR, 32'h200);
    push(0, WR, 32'h200, 1'b0, 1'b1, int'(TO) + 1, cyc + 1, 0);
    wait_done();
    req_i[0] = 1'b0;
    tick(3);

    // Source filtering: cache2's own shared must not leak into bus_shared_o
    ack_mask = 4'b1111; shr_mask = 4'b0100;
    set_req(2, RD, 32'h300);
    push(2, RD, 32'h300, 1'b0, 1'b0, 2, cyc + 1, 0);
    wait_done();
    req_i[2] = 1'b0;
    tick(3);

    // NOP requester never granted; cache0 withdraws during SNOOP yet completes
    ack_mask = 4'b1111; shr_mask = 4'b0010; ack_dly = 2;
    set_req(1, NOP, 32'h500);
    set_req(0, WR, 32'h400);
    push(0, WR, 32'h400, 1'b1, 1'b0, 3, cyc + 1, 0);
    wait_bus();
    req_i[0] = 1'b0;
    wait_done();
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_valid_o || gnt_o != '0) seen++;
    end
    check_eq("nop_never_granted", 64'(seen), 64'd0);
    req_i = '0;
    tick(2);

    check_eq("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
